// File: rtl/sh_multi_timer_if.sv
// ---------------------------------------------------------------------------
// sh_multi_timer_if
//
// Internal peripheral bus (DBUS) bundle used by sh_multi_timer.
//
// Signals:
//   IBUS_A     byte address                  (master -> slave)
//   IBUS_DI    write data                    (master -> slave)
//   IBUS_BA    byte enables, BA[i] = bits 8i+7:8i (master -> slave)
//   IBUS_WE    write strobe                  (master -> slave)
//   IBUS_REQ   access request                (master -> slave)
//   IBUS_DO    read data                     (slave -> master)
//   IBUS_BUSY  wait request                  (slave -> master)
//   IBUS_ACT   address hit                   (slave -> master)
// ---------------------------------------------------------------------------
interface sh_multi_timer_if;
  logic [31:0] IBUS_A;
  logic [31:0] IBUS_DI;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE;
  logic        IBUS_REQ;
  logic [31:0] IBUS_DO;
  logic        IBUS_BUSY;
  logic        IBUS_ACT;

  modport master (
    output IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
    input  IBUS_DO, IBUS_BUSY, IBUS_ACT
  );

  modport slave (
    input  IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ,
    output IBUS_DO, IBUS_BUSY, IBUS_ACT
  );
endinterface

// File: rtl/sh_multi_timer.sv
// ---------------------------------------------------------------------------
// sh_multi_timer
//
// N-channel compare-match timer for the SH internal peripheral bus.
// Each channel has CTRL/COUNT/COMPARE/STATUS registers at BASE_ADDR + c*16,
// a selectable count source (shared /8, /32, /128 prescaler or a
// synchronised external TCLK rising edge), auto-clear, one-shot, a toggle
// output and a registered level interrupt.
//
// Ports:
//   CLK    system clock
//   RST_N  asynchronous active-low reset
//   CE_R   clock enable; qualifies every state update
//   EN     global enable
//   RES_N  synchronous active-low soft reset, sampled on CE_R
//   SBY    standby: freezes counters and prescaler, bus stays usable
//   TCLK   per-channel asynchronous external count clocks
//   ibus   DBUS slave port (address/data/byte-enable/strobes, read data,
//          BUSY tied low, ACT = address hit)
//   IRQ    per-channel level interrupt
//   TOUT   per-channel compare toggle output
// ---------------------------------------------------------------------------
module sh_multi_timer #(
  parameter int          CHANNELS  = 4,
  parameter int          WIDTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFE40
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                CE_R,
  input  logic                EN,
  input  logic                RES_N,
  input  logic                SBY,
  input  logic [CHANNELS-1:0] TCLK,
  sh_multi_timer_if.slave     ibus,
  output logic [CHANNELS-1:0] IRQ,
  output logic [CHANNELS-1:0] TOUT
);

  localparam logic [31:0] RANGE = 32'(CHANNELS * 16);

  // Common qualifiers
  logic ce;        // general state-update enable
  logic count_en;  // counters and prescaler may advance
  logic soft_rst;  // RES_N sampled on CE_R

  assign ce       = CE_R & EN;
  assign count_en = CE_R & EN & ~SBY;
  assign soft_rst = CE_R & ~RES_N;

  // -------------------------------------------------------------------------
  // Bus decode
  // -------------------------------------------------------------------------
  logic [31:0] off;
  logic        hit;
  logic [2:0]  ch_idx;
  logic [1:0]  reg_sel;
  logic        wr_en;
  logic [31:0] lane_mask;
  logic [WIDTH-1:0] wr_mask;
  logic [WIDTH-1:0] wr_data;
  logic [CHANNELS-1:0][31:0] rd_word;
  logic [31:0] do_v;

  assign off     = ibus.IBUS_A - BASE_ADDR;
  // Lower-bound test catches addresses that wrap around below BASE_ADDR.
  assign hit     = ibus.IBUS_REQ & (ibus.IBUS_A >= BASE_ADDR) & (off < RANGE);
  assign ch_idx  = off[6:4];
  assign reg_sel = off[3:2];
  assign wr_en   = ce & hit & ibus.IBUS_WE;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_mask[8*gi +: 8] = {8{ibus.IBUS_BA[gi]}};
  end

  assign wr_mask = lane_mask[WIDTH-1:0];
  assign wr_data = ibus.IBUS_DI[WIDTH-1:0];

  always_comb begin
    do_v = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (hit && (ch_idx == 3'(c))) begin
        do_v = rd_word[c];
      end
    end
  end

  assign ibus.IBUS_DO   = do_v;
  assign ibus.IBUS_ACT  = hit;
  assign ibus.IBUS_BUSY = 1'b0;

  // -------------------------------------------------------------------------
  // Shared prescaler
  // -------------------------------------------------------------------------
  logic [6:0] presc_q, presc_d;
  logic       p8, p32, p128;

  // Divider ticks are taken from the value about to roll over, so a tick
  // coincides with the cycle the prescaler advances past the boundary.
  assign p8   = &presc_q[2:0];
  assign p32  = &presc_q[4:0];
  assign p128 = &presc_q[6:0];

  always_comb begin
    presc_d = presc_q;
    if (count_en) begin
      presc_d = presc_q + 7'd1;
    end
    if (soft_rst) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{ibus.IBUS_DI, lane_mask, off};

  // -------------------------------------------------------------------------
  // Channels
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [7:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] compare_q, compare_d;
    logic             cmf_q, cmf_d;
    logic             ovf_q, ovf_d;
    logic             tout_q, tout_d;
    logic             irq_q, irq_d;
    logic             s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic             tclk_edge;
    logic             src_tick;
    logic             tick;
    logic             is_match;
    logic             is_ones;
    logic             wr_ch;
    logic             cmf_set;
    logic             ovf_set;
    logic [31:0]      rd_c;

    // TCLK: two-flop synchroniser plus edge register, advanced on CE_R only.
    always_comb begin
      s1_d   = s1_q;
      s2_d   = s2_q;
      prev_d = prev_q;
      if (CE_R) begin
        s1_d   = TCLK[gi];
        s2_d   = s1_q;
        prev_d = s2_q;
      end
      if (soft_rst) begin
        s1_d   = 1'b0;
        s2_d   = 1'b0;
        prev_d = 1'b0;
      end
    end

    assign tclk_edge = s2_q & ~prev_q;

    always_comb begin
      case (ctrl_q[2:1])
        2'b00:   src_tick = p8;
        2'b01:   src_tick = p32;
        2'b10:   src_tick = p128;
        default: src_tick = tclk_edge;
      endcase
    end

    assign tick     = ctrl_q[0] & src_tick & count_en;
    assign is_match = (count_q == compare_q);
    assign is_ones  = &count_q;
    assign wr_ch    = wr_en & (ch_idx == 3'(gi));

    always_comb begin
      ctrl_d    = ctrl_q;
      count_d   = count_q;
      compare_d = compare_q;
      tout_d    = tout_q;
      irq_d     = irq_q;
      cmf_set   = 1'b0;
      ovf_set   = 1'b0;

      if (tick) begin
        if (is_match) begin
          cmf_set = 1'b1;
          if (ctrl_q[7]) begin
            tout_d = ~tout_q;
          end
          if (ctrl_q[3]) begin
            count_d = '0;
          end else begin
            // Match at all-ones without auto-clear still wraps and overflows.
            count_d = count_q + 1'b1;
            ovf_set = is_ones;
          end
          if (ctrl_q[4]) begin
            ctrl_d[0] = 1'b0;
          end
        end else if (is_ones) begin
          count_d = '0;
          ovf_set = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      cmf_d = cmf_q | cmf_set;
      ovf_d = ovf_q | ovf_set;

      // Bus writes are applied after the tick so they override COUNT and the
      // one-shot START clear; hardware flag sets still beat a W1C.
      if (wr_ch) begin
        case (reg_sel)
          2'd0: begin
            if (ibus.IBUS_BA[0]) begin
              ctrl_d = ibus.IBUS_DI[7:0];
            end
          end
          2'd1: count_d   = (count_d & ~wr_mask) | (wr_data & wr_mask);
          2'd2: compare_d = (compare_q & ~wr_mask) | (wr_data & wr_mask);
          default: begin
            if (ibus.IBUS_BA[0]) begin
              cmf_d = (cmf_q & ~ibus.IBUS_DI[0]) | cmf_set;
              ovf_d = (ovf_q & ~ibus.IBUS_DI[1]) | ovf_set;
            end
          end
        endcase
      end

      if (ce) begin
        irq_d = (cmf_q & ctrl_q[5]) | (ovf_q & ctrl_q[6]);
      end

      if (soft_rst) begin
        ctrl_d    = '0;
        count_d   = '0;
        compare_d = '1;
        cmf_d     = 1'b0;
        ovf_d     = 1'b0;
        tout_d    = 1'b0;
        irq_d     = 1'b0;
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        ctrl_q    <= '0;
        count_q   <= '0;
        compare_q <= '1;
        cmf_q     <= 1'b0;
        ovf_q     <= 1'b0;
        tout_q    <= 1'b0;
        irq_q     <= 1'b0;
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        prev_q    <= 1'b0;
      end else begin
        ctrl_q    <= ctrl_d;
        count_q   <= count_d;
        compare_q <= compare_d;
        cmf_q     <= cmf_d;
        ovf_q     <= ovf_d;
        tout_q    <= tout_d;
        irq_q     <= irq_d;
        s1_q      <= s1_d;
        s2_q      <= s2_d;
        prev_q    <= prev_d;
      end
    end

    always_comb begin
      rd_c = '0;
      case (reg_sel)
        2'd0:    rd_c[7:0]       = ctrl_q;
        2'd1:    rd_c[WIDTH-1:0] = count_q;
        2'd2:    rd_c[WIDTH-1:0] = compare_q;
        default: rd_c[1:0]       = {ovf_q, cmf_q};
      endcase
    end

    assign rd_word[gi] = rd_c;
    assign IRQ[gi]     = irq_q;
    assign TOUT[gi]    = tout_q;
  end

endmodule
